fsm_ring_seq: RTL and testbench

FSM_RING_SEQ -- requirements
Module: fsm_ring_seq

---
 rtl/fsm_ring_pkg.sv | 27 ++
 rtl/fsm_sat_counter.sv | 45 ++++
 rtl/fsm_ring_seq.sv | 145 ++++++++++++++
 tb/tb_fsm_ring_seq.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/fsm_ring_pkg.sv
// -----------------------------------------------------------------------------
// fsm_ring_pkg
// Shared definitions for the ring sequencer:
//   - legal parameter limits for fsm_ring_seq
//   - dir_e step-direction encoding
//   - state_width(): bits needed to hold a ring state index (minimum 1)
// -----------------------------------------------------------------------------
package fsm_ring_pkg;

  localparam int NUM_STATES_MIN = 2;
  localparam int NUM_STATES_MAX = 16;
  localparam int WRAP_CNT_W_MIN = 1;
  localparam int WRAP_CNT_W_MAX = 16;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  // Width of a state index; a 2-state ring still needs one bit.
  function automatic int state_width(input int num_states);
    int w;
    w = $clog2(num_states);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fsm_sat_counter.sv
// -----------------------------------------------------------------------------
// fsm_sat_counter
// W-bit up counter that stops at all-ones instead of rolling over.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-low reset, clears cnt
//   inc - count enable, one increment per cycle while high
//   cnt - current count
// -----------------------------------------------------------------------------
module fsm_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  // Next count: increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fsm_ring_seq.sv
// -----------------------------------------------------------------------------
// fsm_ring_seq
// Ring sequencer of NUM_STATES states stepping up or down on request, with a
// synchronous load, a one-cycle wrap pulse, a one-cycle out-of-range-load
// pulse and an optional saturating wrap counter.
//
// Build option: define FSM_RING_WRAP_CNT_EN to instantiate the wrap counter.
// Without it wrap_cnt is tied to zero and no counter flops exist.
//
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-low reset (beats load and din)
//   din       - advance request
//   dir       - step direction when din=1 (0 = up, 1 = down)
//   load      - load request (beats din)
//   load_val  - value to load; out-of-range values load 0 and flag load_err
//   state_o   - current state index
//   dout      - 1 while state_o == OUT_STATE (decoded from the register only)
//   wrap      - 1 for the cycle following a wrapping step
//   load_err  - 1 for the cycle following an out-of-range load
//   wrap_cnt  - saturating number of wraps (0 when the counter is not built)
// -----------------------------------------------------------------------------
module fsm_ring_seq
  import fsm_ring_pkg::*;
#(
  parameter  int NUM_STATES = 3,
  parameter  int OUT_STATE  = 2,
  parameter  int WRAP_CNT_W = 8,
  localparam int SW         = state_width(NUM_STATES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din,
  input  logic                  dir,
  input  logic                  load,
  input  logic [SW-1:0]         load_val,
  output logic [SW-1:0]         state_o,
  output logic                  dout,
  output logic                  wrap,
  output logic                  load_err,
  output logic [WRAP_CNT_W-1:0] wrap_cnt
);

  // Illegal configurations stop elaboration.
  if ((NUM_STATES < NUM_STATES_MIN) || (NUM_STATES > NUM_STATES_MAX)) begin : g_bad_num_states
    $error("fsm_ring_seq: NUM_STATES out of range");
  end
  if ((OUT_STATE < 0) || (OUT_STATE > NUM_STATES - 1)) begin : g_bad_out_state
    $error("fsm_ring_seq: OUT_STATE out of range");
  end
  if ((WRAP_CNT_W < WRAP_CNT_W_MIN) || (WRAP_CNT_W > WRAP_CNT_W_MAX)) begin : g_bad_wrap_cnt_w
    $error("fsm_ring_seq: WRAP_CNT_W out of range");
  end

  localparam logic [SW-1:0] LAST_S  = SW'(NUM_STATES - 1);
  localparam logic [SW-1:0] OUT_S   = SW'(OUT_STATE);
  localparam logic [SW-1:0] ZERO_S  = {SW{1'b0}};
  localparam logic [SW-1:0] ONE_S   = {{(SW-1){1'b0}}, 1'b1};

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;
  logic          wrap_q;
  logic          wrap_d;
  logic          load_err_q;
  logic          load_err_d;
  dir_e          dir_s;

  assign dir_s = dir_e'(dir);

  // Next state and pulse flags: load, then illegal-state recovery, then step, else hold.
  always_comb begin
    state_d    = state_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_val > LAST_S) begin
        state_d    = ZERO_S;
        load_err_d = 1'b1;
      end else begin
        state_d    = load_val;
      end
    end else if (state_q > LAST_S) begin
      // Unreachable encoding (non-power-of-two ring): fall back to 0.
      state_d = ZERO_S;
    end else if (din) begin
      case (dir_s)
        DIR_UP: begin
          if (state_q == LAST_S) begin
            state_d = ZERO_S;
            wrap_d  = 1'b1;
          end else begin
            state_d = state_q + ONE_S;
          end
        end
        DIR_DN: begin
          if (state_q == ZERO_S) begin
            state_d = LAST_S;
            wrap_d  = 1'b1;
          end else begin
            state_d = state_q - ONE_S;
          end
        end
        default: begin
          state_d = ZERO_S;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and pulse registers; wrap/load_err are rewritten every edge so they last one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ZERO_S;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign state_o  = state_q;
  assign dout     = (state_q == OUT_S);
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

`ifdef FSM_RING_WRAP_CNT_EN
  // Counter advances on the same edge that raises wrap, so wrap_cnt already
  // includes the wrap being flagged.
  fsm_sat_counter #(
    .W (WRAP_CNT_W)
  ) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .inc (wrap_d),
    .cnt (wrap_cnt)
  );
`else
  assign wrap_cnt = {WRAP_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fsm_ring_seq.sv
module tb_fsm_ring_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: defaults (3 states, OUT_STATE 2, 8-bit counter)
  logic       a_rst = 1'b0, a_din = 1'b0, a_dir = 1'b0, a_load = 1'b0;
  logic [1:0] a_load_val = 2'd0;
  logic [1:0] a_state;
  logic       a_dout, a_wrap, a_load_err;
  logic [7:0] a_wrap_cnt;

  // DUT B: 2 states, OUT_STATE 1, 2-bit counter
  logic       b_rst = 1'b0, b_din = 1'b0, b_dir = 1'b0, b_load = 1'b0;
  logic [0:0] b_load_val = 1'b0;
  logic [0:0] b_state;
  logic       b_dout, b_wrap, b_load_err;
  logic [1:0] b_wrap_cnt;

  fsm_ring_seq u_dut_a (
    .clk(clk), .rst(a_rst), .din(a_din), .dir(a_dir), .load(a_load),
    .load_val(a_load_val), .state_o(a_state), .dout(a_dout), .wrap(a_wrap),
    .load_err(a_load_err), .wrap_cnt(a_wrap_cnt)
  );

  fsm_ring_seq #(.NUM_STATES(2), .OUT_STATE(1), .WRAP_CNT_W(2)) u_dut_b (
    .clk(clk), .rst(b_rst), .din(b_din), .dir(b_dir), .load(b_load),
    .load_val(b_load_val), .state_o(b_state), .dout(b_dout), .wrap(b_wrap),
    .load_err(b_load_err), .wrap_cnt(b_wrap_cnt)
  );

  typedef struct {
    int    dut;
    string name;
    int    st;
    logic  dout;
    logic  wrap;
    logic  lerr;
    int    cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %0h expected %0h", nm, fld, act, exp);
    end
  endtask

  task automatic push(input int dut, input string nm, input int st, input logic dout,
                      input logic wrap, input logic lerr, input int cnt);
    exp_t e;
    e.dut  = dut;
    e.name = nm;
    e.st   = st;
    e.dout = dout;
    e.wrap = wrap;
    e.lerr = lerr;
`ifdef FSM_RING_WRAP_CNT_EN
    e.cnt  = cnt;
`else
    e.cnt  = 0;
`endif
    sb_q.push_back(e);
  endtask

  task automatic step_a(input logic r, input logic l, input logic [1:0] lv, input logic d,
                        input logic dr, input string nm, input int st, input logic dout,
                        input logic wrap, input logic lerr, input int cnt);
    a_rst = r; a_load = l; a_load_val = lv; a_din = d; a_dir = dr;
    @(posedge clk);
    #1;
    push(0, nm, st, dout, wrap, lerr, cnt);
  endtask

  task automatic step_b(input logic r, input logic l, input logic [0:0] lv, input logic d,
                        input logic dr, input string nm, input int st, input logic dout,
                        input logic wrap, input logic lerr, input int cnt);
    b_rst = r; b_load = l; b_load_val = lv; b_din = d; b_dir = dr;
    @(posedge clk);
    #1;
    push(1, nm, st, dout, wrap, lerr, cnt);
  endtask

  // Monitor: outputs are valid every cycle; compare at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.dut == 0) begin
          chk(e.name, "state",    16'(a_state),    16'(e.st));
          chk(e.name, "dout",     16'(a_dout),     16'(e.dout));
          chk(e.name, "wrap",     16'(a_wrap),     16'(e.wrap));
          chk(e.name, "load_err", 16'(a_load_err), 16'(e.lerr));
          chk(e.name, "wrap_cnt", 16'(a_wrap_cnt), 16'(e.cnt));
        end else begin
          chk(e.name, "state",    16'(b_state),    16'(e.st));
          chk(e.name, "dout",     16'(b_dout),     16'(e.dout));
          chk(e.name, "wrap",     16'(b_wrap),     16'(e.wrap));
          chk(e.name, "load_err", 16'(b_load_err), 16'(e.lerr));
          chk(e.name, "wrap_cnt", 16'(b_wrap_cnt), 16'(e.cnt));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //      rst   load  lv    din   dir                st dout wrap lerr cnt
    step_a(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "a_reset",     0, 1'b0, 1'b0, 1'b0, 0);
    step_a(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, "a_hold0",     0, 1'b0, 1'b0, 1'b0, 0);
    step_a(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, "a_up1",       1, 1'b0, 1'b0, 1'b0, 0);
    step_a(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, "a_up2",       2, 1'b1, 1'b0, 1'b0, 0);
    step_a(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, "a_up_wrap",   0, 1'b0, 1'b1, 1'b0, 1);
    step_a(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, "a_hold_clr",  0, 1'b0, 1'b0, 1'b0, 1);
    step_a(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, "a_dn_wrap",   2, 1'b1, 1'b1, 1'b0, 2);
    step_a(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, "a_dn1",       1, 1'b0, 1'b0, 1'b0, 2);
    step_a(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, "a_load_oor",  0, 1'b0, 1'b0, 1'b1, 2);
    step_a(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, "a_lerr_clr",  0, 1'b0, 1'b0, 1'b0, 2);
    step_a(1'b1, 1'b1, 2'd1, 1'b1, 1'b0, "a_load_din",  1, 1'b0, 1'b0, 1'b0, 2);
    step_a(1'b1, 1'b1, 2'd2, 1'b1, 1'b1, "a_load2",     2, 1'b1, 1'b0, 1'b0, 2);
    step_a(1'b1, 1'b1, 2'd0, 1'b1, 1'b0, "a_load_nowr", 0, 1'b0, 1'b0, 1'b0, 2);
    step_a(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, "a_dn_wrap2",  2, 1'b1, 1'b1, 1'b0, 3);
    step_a(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, "a_rst_ovr",   0, 1'b0, 1'b0, 1'b0, 0);
    step_a(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, "a_hold_dir",  0, 1'b0, 1'b0, 1'b0, 0);

    step_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "b_reset",     0, 1'b0, 1'b0, 1'b0, 0);
    // Two-state ring stepping up: wrap on every second edge, counter stops at 3.
    for (int i = 1; i <= 12; i++) begin
      step_b(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, $sformatf("b_up%0d", i),
             i % 2, (i % 2) == 1, (i % 2) == 0, 1'b0, (i / 2 > 3) ? 3 : i / 2);
    end
    // Alternating direction wraps on consecutive edges.
    step_b(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "b_dn_wrap",   1, 1'b1, 1'b1, 1'b0, 3);
    step_b(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "b_up_wrap",   0, 1'b0, 1'b1, 1'b0, 3);
    step_b(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "b_dn_wrap2",  1, 1'b1, 1'b1, 1'b0, 3);
    step_b(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "b_load1",     1, 1'b1, 1'b0, 1'b0, 3);
    step_b(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "b_reset2",    0, 1'b0, 1'b0, 1'b0, 0);

    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
